// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: one val/rdy request + val response memory port.
// The master side issues requests and consumes responses; the slave side
// accepts requests and produces responses. Used for the imem and dmem
// requester ports and for the shared downstream memory port.
interface mem_req_arbiter_if #(
   parameter int p_addr_nbits = 32,
   parameter int p_data_nbits = 32
) ();
   logic                    req_val;
   logic                    req_rdy;
   logic                    req_type;   // 0=read, 1=write
   logic [p_addr_nbits-1:0] req_addr;
   logic [p_data_nbits-1:0] req_wdata;
   logic                    resp_val;
   logic [p_data_nbits-1:0] resp_data;

   modport master (
      output req_val, req_type, req_addr, req_wdata,
      input  req_rdy, resp_val, resp_data
   );

   modport slave (
      input  req_val, req_type, req_addr, req_wdata,
      output req_rdy, resp_val, resp_data
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one memory port between the instruction-fetch
// (imem) and data (dmem) requesters, one transaction at a time:
// accept (IDLE) -> issue (ISSUE) -> wait for response (WAIT) -> respond (RESP).
// Default arbitration is fixed dmem-over-imem priority. Defining
// MEM_REQ_ARBITER_RR_EN switches to round-robin between contending requesters.
module mem_req_arbiter #(
   parameter int p_addr_nbits = 32,
   parameter int p_data_nbits = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_req_arbiter_if.slave     imem,
   mem_req_arbiter_if.slave     dmem,
   mem_req_arbiter_if.master    mem
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic OWN_IMEM = 1'b0;
   localparam logic OWN_DMEM = 1'b1;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_owner;
   logic                    r_type;
   logic [p_addr_nbits-1:0] r_addr;
   logic [p_data_nbits-1:0] r_wdata;
   logic [p_data_nbits-1:0] r_iresp_data;
   logic [p_data_nbits-1:0] r_dresp_data;

   logic                    w_pick_i;
   logic                    w_pick_d;
   logic                    w_can_grant;
   logic                    w_grant_i;
   logic                    w_grant_d;
   logic                    w_grant;
   logic                    w_issue;

`ifdef MEM_REQ_ARBITER_RR_EN
   logic r_last_grant;

   // round-robin pick: under contention favour whoever was not granted last
   always_comb begin
      w_pick_d = dmem.req_val && (!imem.req_val || (r_last_grant == OWN_IMEM));
      w_pick_i = imem.req_val && !w_pick_d;
   end

   // remember the most recent grant winner
   always_ff @(posedge clk) begin
      if (rst)          r_last_grant <= OWN_IMEM;
      else if (w_grant) r_last_grant <= w_grant_d;
   end
`else
   // fixed priority: imem only wins when dmem is not asking
   always_comb begin
      w_pick_d = dmem.req_val;
      w_pick_i = imem.req_val && !dmem.req_val;
   end
`endif

   // grants only happen in IDLE and never while reset is asserted
   assign w_can_grant = (r_state == IDLE) && !rst;
   assign w_grant_i   = w_can_grant && w_pick_i;
   assign w_grant_d   = w_can_grant && w_pick_d;
   assign w_grant     = w_grant_i || w_grant_d;
   assign w_issue     = (r_state == ISSUE);

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_grant)          w_state_nxt = ISSUE;
         ISSUE:   if (mem.req_rdy)      w_state_nxt = WAIT;
         WAIT:    if (mem.resp_val)     w_state_nxt = RESP;
         RESP:                          w_state_nxt = IDLE;
         default:                       w_state_nxt = IDLE;
      endcase
   end

   // latch the granted request, then the response data for its owner
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner      <= OWN_IMEM;
         r_type       <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_iresp_data <= '0;
         r_dresp_data <= '0;
      end else begin
         if (w_grant) begin
            r_owner <= w_grant_d;
            r_type  <= w_grant_d ? dmem.req_type  : 1'b0;
            r_addr  <= w_grant_d ? dmem.req_addr  : imem.req_addr;
            r_wdata <= w_grant_d ? dmem.req_wdata : '0;
         end
         if ((r_state == WAIT) && mem.resp_val) begin
            if (r_owner == OWN_DMEM) r_dresp_data <= r_type ? '0 : mem.resp_data;
            else                     r_iresp_data <= mem.resp_data;
         end
      end
   end

   assign imem.req_rdy   = w_grant_i;
   assign dmem.req_rdy   = w_grant_d;

   // memory request fields read as zero whenever no request is being issued
   assign mem.req_val    = w_issue;
   assign mem.req_type   = w_issue && r_type;
   assign mem.req_addr   = w_issue ? r_addr  : '0;
   assign mem.req_wdata  = w_issue ? r_wdata : '0;

   // response data holds its last value; only resp_val qualifies it
   assign imem.resp_val  = (r_state == RESP) && (r_owner == OWN_IMEM);
   assign dmem.resp_val  = (r_state == RESP) && (r_owner == OWN_DMEM);
   assign imem.resp_data = r_iresp_data;
   assign dmem.resp_data = r_dresp_data;
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one val/rdy memory port between the processor's instruction-fetch (imem) and data (dmem) requesters.
- Sits between a multicycle TinyRV1 core and the test/main memory.
- Sequences one transaction at a time: accept, issue, wait, respond.
- Routes the response back to the owning requester.

Parameters:
- p_addr_nbits, 32, width of all address fields
- p_data_nbits, 32, width of all data fields

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imemreq_val  in  1  fetch request valid
- imemreq_rdy  out  1  fetch request accepted this cycle
- imemreq_addr  in  p_addr_nbits  fetch address
- imemresp_val  out  1  fetch response valid (one-cycle pulse)
- imemresp_data  out  p_data_nbits  fetch data
- dmemreq_val  in  1  data request valid
- dmemreq_rdy  out  1  data request accepted this cycle
- dmemreq_type  in  1  0=read, 1=write
- dmemreq_addr  in  p_addr_nbits  data address
- dmemreq_wdata  in  p_data_nbits  write data
- dmemresp_val  out  1  data response valid (one-cycle pulse; also pulses for writes)
- dmemresp_rdata  out  p_data_nbits  read data (0 for writes)
- memreq_val  out  1  memory request valid
- memreq_rdy  in  1  memory accepts request
- memreq_type  out  1  0=read, 1=write
- memreq_addr  out  p_addr_nbits  memory address
- memreq_wdata  out  p_data_nbits  memory write data
- memresp_val  in  1  memory response valid
- memresp_rdata  in  p_data_nbits  memory read data

Behaviour:
- Single clock clk; rst synchronous, active-high.
- Reset:
  - state=IDLE; owner=imem; last_grant=imem.
  - All *_rdy, *_val outputs 0; all data/addr/type outputs 0.
  - Any in-flight transaction is dropped silently; no response is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant per arbitration rule; granted requester's *_rdy=1 combinationally (only if its val=1 and rst=0).
  - On grant, latch owner, type (imem forces read), addr, wdata; go to ISSUE.
  - No valid request: stay in IDLE.
- Arbitration (default): fixed priority, dmem over imem; imem is granted only when dmemreq_val=0.
- ISSUE:
  - memreq_val=1; memreq_* driven from latched registers and held stable until memreq_rdy.
  - memreq_val && memreq_rdy: go to WAIT.
  - Otherwise stay in ISSUE indefinitely (no timeout).
- WAIT:
  - memreq_val=0.
  - On memresp_val=1, latch memresp_rdata (0 if write); go to RESP.
- RESP:
  - Owner's *resp_val=1 with latched data for exactly one cycle; the other requester's resp_val=0.
  - Unconditionally return to IDLE.
- Both *_rdy are 0 in ISSUE, WAIT and RESP. Requesters hold val/addr until their rdy is seen.
- memresp_val in IDLE, ISSUE or RESP is ignored (no state change, no latch).
- Latency:
  - Accept at cycle N.
  - memreq_val first asserted at N+1.
  - Memory handshake at cycle H ≥ N+1; memresp_val earliest at H+1.
  - Requester resp_val one cycle after memresp_val.
  - Minimum accept-to-response: 3 cycles.
- Throughput: at most one transaction per 4 cycles. Back-to-back: a new grant can occur in the IDLE cycle after RESP.
- resp data outputs hold their last value outside RESP. Only resp_val qualifies them.
- Simultaneous rst with any handshake: rst wins; no rdy asserted, nothing latched.

Optional Feature:
- Macro: MEM_REQ_ARBITER_RR_EN
- Defined:
  - Round-robin arbitration. When both requesters are valid in IDLE, grant the one not equal to last_grant.
  - last_grant updates on every grant.
  - Reset last_grant=imem, so the first contended grant goes to dmem.
  - Single valid requester: always granted.
- Undefined:
  - Fixed dmem-over-imem priority.
  - last_grant register is not present.

Test Plan:
- imem read: imemreq_val=1, addr=0x00000200; memreq_rdy=1; memory returns 0x00A00093 one cycle after handshake -> imemreq_rdy pulse at N; memreq_val/addr=0x200 at N+1; imemresp_val=1, data=0x00A00093 at N+3; dmemresp_val=0 throughout.
- dmem write: type=1, addr=0x2000, wdata=0xDEADBEEF -> memreq_type=1, memreq_wdata=0xDEADBEEF; dmemresp_val pulse with rdata=0.
- Contention, macro undefined: imem and dmem both valid for 3 transactions -> dmem, dmem, dmem granted; imem granted only after dmemreq_val drops.
- Contention, macro defined: both continuously valid -> grant order dmem, imem, dmem, imem; each response is routed to its correct owner.
- Memory stall: memreq_rdy=0 for 3 cycles, then memresp_val delayed 2 cycles -> memreq_* held stable through the stall; both *_rdy=0; exactly one resp_val pulse; spurious memresp_val injected in IDLE is ignored.
- Reset in WAIT: rst=1 for 1 cycle -> state IDLE; no resp_val; next imem request completes normally with correct data.
